multdiv_unit: RTL and testbench

Multi-cycle multiply/divide unit with HI/LO registers, placed in the EX stage. It is the producing end of the mult/div stall interface: it accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and drives a busy/stall request that the hazard unit combines with its register-hazard stalls. It holds HI/LO for MFHI/MFLO reads. Results commit after a fixed, parameterised latency.

---
 rtl/multdiv_unit_pkg.sv | 42 ++++
 rtl/multdiv_unit_divider.sv | 41 ++++
 rtl/multdiv_unit.sv | 138 +++++++++++++
 tb/tb_multdiv_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/multdiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, default latencies.
// MULTDIV_MADD_EN adds the MADD/MADDU/MSUB/MSUBU ops to the mult/div class.
package multdiv_unit_pkg;

    localparam int unsigned WIDTH_MDOP      = 4;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic [WIDTH_MDOP-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Ops that occupy the unit for a multi-cycle latency (MTHI/MTLO do not).
    function automatic logic is_md_class(logic [WIDTH_MDOP-1:0] op);
        logic res;
        res = 1'b0;
        case (md_op_e'(op))
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: res = 1'b1;
`ifdef MULTDIV_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: res = 1'b1;
`endif
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/multdiv_unit_divider.sv
// Combinational 32-bit signed/unsigned divider with divide-by-zero and
// signed-overflow handling. Unaffected by MULTDIV_MADD_EN.
module md_divider (
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        signed_i,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] safe_b;
    logic [31:0] uq;
    logic [31:0] ur;

    always_comb begin
        neg_a  = signed_i & dividend_i[31];
        neg_b  = signed_i & divisor_i[31];
        abs_a  = neg_a ? (32'd0 - dividend_i) : dividend_i;
        abs_b  = neg_b ? (32'd0 - divisor_i) : divisor_i;
        // Keep the magnitude divider free of a zero divisor; that case is overridden below.
        safe_b = (divisor_i == 32'd0) ? 32'd1 : abs_b;
        uq     = abs_a / safe_b;
        ur     = abs_a % safe_b;

        quot_o = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
        rem_o  = neg_a ? (32'd0 - ur) : ur;

        if (divisor_i == 32'd0) begin
            quot_o = 32'hFFFF_FFFF;
            rem_o  = dividend_i;
        end else if (signed_i && dividend_i == 32'h8000_0000 && divisor_i == 32'hFFFF_FFFF) begin
            quot_o = 32'h8000_0000;
            rem_o  = 32'd0;
        end
    end

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO, results committed after a fixed latency.
// Define MULTDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulate ops.
module multdiv_unit
    import multdiv_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH_MDOP-1:0] md_op,
    input  logic [31:0]           rs_val,
    input  logic [31:0]           rt_val,
    output logic                  busy,
    output logic                  md_stall,
    output logic [31:0]           hi,
    output logic [31:0]           lo
);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] p_hi_q, p_hi_d;
    logic [31:0] p_lo_q, p_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    md_op_e      op;
    logic        signed_mul;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] prod;
    logic [31:0] div_q;
    logic [31:0] div_r;
`ifdef MULTDIV_MADD_EN
    logic [63:0] acc;
`endif

    md_divider u_div (
        .dividend_i (rs_val),
        .divisor_i  (rt_val),
        .signed_i   (op == MD_DIV),
        .quot_o     (div_q),
        .rem_o      (div_r)
    );

    // Sign/zero-extending to 64 bits makes the truncated 64x64 product correct for both.
    always_comb begin
        op         = md_op_e'(md_op);
        signed_mul = (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB);
        mul_a      = signed_mul ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
        mul_b      = signed_mul ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
        prod       = mul_a * mul_b;
    end

`ifdef MULTDIV_MADD_EN
    always_comb begin
        acc = {hi_q, lo_q};
        if (op == MD_MADD || op == MD_MADDU) begin
            acc = {hi_q, lo_q} + prod;
        end else if (op == MD_MSUB || op == MD_MSUBU) begin
            acc = {hi_q, lo_q} - prod;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            {p_hi_d, p_lo_d} = prod;
                            cnt_d            = 4'(MULT_CYCLES);
                            state_d          = ST_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            p_lo_d  = div_q;
                            p_hi_d  = div_r;
                            cnt_d   = 4'(DIV_CYCLES);
                            state_d = ST_RUN;
                        end
`ifdef MULTDIV_MADD_EN
                        MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: begin
                            {p_hi_d, p_lo_d} = acc;
                            cnt_d            = 4'(MULT_CYCLES);
                            state_d          = ST_RUN;
                        end
`endif
                        MD_MTHI: hi_d = rs_val;
                        MD_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = p_hi_q;
                    lo_d    = p_lo_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            p_hi_q  <= 32'd0;
            p_lo_q  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign md_stall = busy | (start & is_md_class(md_op));
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: latency, HI/LO results, stall and reset abort.
// Build with MULTDIV_MADD_EN defined to cover the accumulate ops.
module tb_multdiv_unit;
    import multdiv_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    multdiv_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) assert (!(start && busy)) else $error("start issued while busy");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; issues the op in this cycle and returns at the first idle negedge.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_n, input logic exp_stall,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        #1;
        check({tag, "_stall_start"}, md_stall, exp_stall);
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        if (exp_n > 0) check({tag, "_stall_busy"}, md_stall, 1'b1);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_cycles"}, n, exp_n);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        md_op  = MD_NONE;
        rs_val = 32'd0;
        rt_val = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_stall", md_stall, 1'b0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("mult",      MD_MULT,  32'hFFFF_FFFE, 32'd3,         5,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        do_op("divu_7_2",  MD_DIVU,  32'd7,         32'd2,         10, 1'b1, 32'd1,         32'd3);
        do_op("div_m7_2",  MD_DIV,   32'hFFFF_FFF9, 32'd2,         10, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div_7_m2",  MD_DIV,   32'd7,         32'hFFFF_FFFE, 10, 1'b1, 32'd1,         32'hFFFF_FFFD);
        do_op("div_m7_m2", MD_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 10, 1'b1, 32'hFFFF_FFFF, 32'd3);
        do_op("divu_big",  MD_DIVU,  32'hFFFF_FFF9, 32'd2,         10, 1'b1, 32'd1,         32'h7FFF_FFFC);
        do_op("div_by0",   MD_DIV,   32'd5,         32'd0,         10, 1'b1, 32'd5,         32'hFFFF_FFFF);
        do_op("divu_by0",  MD_DIVU,  32'hFFFF_FFFF, 32'd0,         10, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b1, 32'd0,         32'h8000_0000);
        do_op("divu_nov",  MD_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b1, 32'h8000_0000, 32'd0);
        do_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  1'b1, 32'hFFFF_FFFE, 32'd1);
        do_op("mthi",      MD_MTHI,  32'hDEAD_BEEF, 32'd0,         0,  1'b0, 32'hDEAD_BEEF, 32'd1);
        do_op("mtlo",      MD_MTLO,  32'h0000_1234, 32'd0,         0,  1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
        do_op("none",      MD_NONE,  32'h5555_5555, 32'd9,         0,  1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
        do_op("bad_op",    4'hF,     32'h5555_5555, 32'd9,         0,  1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
`ifdef MULTDIV_MADD_EN
        do_op("mthi0",     MD_MTHI,  32'd0,         32'd0,         0,  1'b0, 32'd0,         32'h0000_1234);
        do_op("mtlo_ff",   MD_MTLO,  32'hFFFF_FFFF, 32'd0,         0,  1'b0, 32'd0,         32'hFFFF_FFFF);
        do_op("maddu",     MD_MADDU, 32'd1,         32'd1,         5,  1'b1, 32'd1,         32'd0);
        do_op("msub",      MD_MSUB,  32'd2,         32'd3,         5,  1'b1, 32'd0,         32'hFFFF_FFFA);
        do_op("madd",      MD_MADD,  32'hFFFF_FFFF, 32'd1,         5,  1'b1, 32'd0,         32'hFFFF_FFF9);
        do_op("msubu",     MD_MSUBU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  1'b1, 32'd2,         32'hFFFF_FFF8);
`else
        do_op("maddu_off", MD_MADDU, 32'd1,         32'd1,         0,  1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
`endif

        // Reset during the third busy cycle must abort without committing.
        start  = 1'b1;
        md_op  = MD_MULTU;
        rs_val = 32'hFFFF_FFFF;
        rt_val = 32'd2;
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        check("abort_busy1", busy, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_abort_busy", busy, 1'b0);
        check("post_abort_hi", hi, 32'd0);
        check("post_abort_lo", lo, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
